// File: rtl/mem_arbiter_pkg.sv
// Shared constants and types for the cache-to-memory arbiter.
package mem_arbiter_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    localparam logic OWNER_I = 1'b0;
    localparam logic OWNER_D = 1'b1;

    // One in-flight read beat as it travels towards the memory's data return.
    typedef struct packed {
        logic valid;
        logic last;
        logic owner;
    } trk_beat_t;

endpackage

// File: rtl/mem_read_tracker.sv
// Delays read-issue tags by the memory latency so each returning word can be
// routed to the cache that asked for it.
module mem_read_tracker
    import mem_arbiter_pkg::*;
#(
    parameter int MEM_LATENCY = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic issue_valid_i,
    input  logic issue_last_i,
    input  logic issue_owner_i,
    output logic resp_valid_o,
    output logic resp_last_o,
    output logic resp_owner_o
);

    trk_beat_t pipe_q [MEM_LATENCY];

    // NOTE: this pipe is control state, not storage: its valid bits must be
    // cleared on reset or stale reads would be reported afterwards.
    always_ff @(posedge clk) begin
        if (rst) begin
            pipe_q <= '{default: '0};
        end else begin
            pipe_q[0] <= '{valid: issue_valid_i, last: issue_last_i, owner: issue_owner_i};
            for (int i = 1; i < MEM_LATENCY; i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
        end
    end

    assign resp_valid_o = pipe_q[MEM_LATENCY-1].valid;
    assign resp_last_o  = pipe_q[MEM_LATENCY-1].valid & pipe_q[MEM_LATENCY-1].last;
    assign resp_owner_o = pipe_q[MEM_LATENCY-1].owner;

endmodule

// File: rtl/mem_arbiter.sv
// Serializes I-cache fills and D-cache fills/write-backs into word beats on a
// single pipelined memory port; D has fixed priority over I.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 16,
    parameter int LINE_WORDS  = 4,
    parameter int MEM_LATENCY = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          i_req_valid,
    input  logic [ADDR_W-1:0]             i_req_addr,
    output logic                          i_req_ready,
    output logic                          i_resp_valid,
    output logic [DATA_W-1:0]             i_resp_data,
    output logic                          i_resp_last,
    input  logic                          d_req_valid,
    input  logic                          d_req_we,
    input  logic [ADDR_W-1:0]             d_req_addr,
    output logic                          d_req_ready,
    output logic                          d_wdata_ready,
    output logic [$clog2(LINE_WORDS)-1:0] d_wbeat,
    input  logic [DATA_W-1:0]             d_wdata,
    output logic                          d_resp_valid,
    output logic [DATA_W-1:0]             d_resp_data,
    output logic                          d_resp_last,
    output logic                          d_wr_done,
    output logic                          mem_en,
    output logic                          mem_we,
    output logic [ADDR_W-1:0]             mem_addr,
    output logic [DATA_W-1:0]             mem_wdata,
    input  logic [DATA_W-1:0]             mem_rdata
);

    localparam int BEAT_W = $clog2(LINE_WORDS);
    localparam int TAG_W  = ADDR_W - BEAT_W;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(LINE_WORDS - 1);

    logic [1:0]        state_q, state_d;
    logic              owner_q, owner_d;
    logic              we_q, we_d;
    logic [TAG_W-1:0]  tag_q, tag_d;
    logic [BEAT_W-1:0] beat_q, beat_d;
    logic              wr_done_q, wr_done_d;

    logic trk_valid, trk_last, trk_owner;
    logic unused_addr_bits;

    // Word-within-line bits of the request addresses are don't-care.
    assign unused_addr_bits = ^{i_req_addr[BEAT_W-1:0], d_req_addr[BEAT_W-1:0]};

    // NOTE: every output of this block gets a default first, so no path
    // through the case statement can infer a latch.
    always_comb begin
        state_d       = state_q;
        owner_d       = owner_q;
        we_d          = we_q;
        tag_d         = tag_q;
        beat_d        = beat_q;
        wr_done_d     = 1'b0;
        i_req_ready   = 1'b0;
        d_req_ready   = 1'b0;
        d_wdata_ready = 1'b0;
        d_wbeat       = '0;
        mem_en        = 1'b0;
        mem_we        = 1'b0;
        mem_addr      = '0;
        mem_wdata     = '0;

        case (state_q)
            ST_IDLE: begin
                if (!rst && d_req_valid) begin
                    d_req_ready = 1'b1;
                    owner_d     = OWNER_D;
                    we_d        = d_req_we;
                    tag_d       = d_req_addr[ADDR_W-1:BEAT_W];
                    beat_d      = '0;
                    state_d     = ST_ISSUE;
                end else if (!rst && i_req_valid) begin
                    i_req_ready = 1'b1;
                    owner_d     = OWNER_I;
                    we_d        = 1'b0;
                    tag_d       = i_req_addr[ADDR_W-1:BEAT_W];
                    beat_d      = '0;
                    state_d     = ST_ISSUE;
                end
            end

            ST_ISSUE: begin
                // Beat index replaces the low bits, so the line never carries into the tag.
                mem_en   = 1'b1;
                mem_we   = we_q;
                mem_addr = {tag_q, beat_q};
                if (we_q) begin
                    d_wdata_ready = 1'b1;
                    d_wbeat       = beat_q;
                    mem_wdata     = d_wdata;
                end
                beat_d = beat_q + BEAT_W'(1);
                if (beat_q == LAST_BEAT) begin
                    beat_d    = '0;
                    wr_done_d = we_q;
                    state_d   = we_q ? ST_IDLE : ST_DRAIN;
                end
            end

            ST_DRAIN: begin
                if (trk_valid && trk_last) begin
                    state_d = ST_IDLE;
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its pre-edge next-state value regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            owner_q   <= OWNER_I;
            we_q      <= 1'b0;
            tag_q     <= '0;
            beat_q    <= '0;
            wr_done_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            we_q      <= we_d;
            tag_q     <= tag_d;
            beat_q    <= beat_d;
            wr_done_q <= wr_done_d;
        end
    end

    mem_read_tracker #(
        .MEM_LATENCY (MEM_LATENCY)
    ) u_tracker (
        .clk           (clk),
        .rst           (rst),
        .issue_valid_i (state_q == ST_ISSUE && !we_q),
        .issue_last_i  (beat_q == LAST_BEAT),
        .issue_owner_i (owner_q),
        .resp_valid_o  (trk_valid),
        .resp_last_o   (trk_last),
        .resp_owner_o  (trk_owner)
    );

    assign d_wr_done = wr_done_q;

    always_comb begin
        i_resp_valid = trk_valid && (trk_owner == OWNER_I);
        d_resp_valid = trk_valid && (trk_owner == OWNER_D);
        i_resp_last  = i_resp_valid && trk_last;
        d_resp_last  = d_resp_valid && trk_last;
        i_resp_data  = i_resp_valid ? mem_rdata : '0;
        d_resp_data  = d_resp_valid ? mem_rdata : '0;
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a latency-2 memory model whose read data
// is the address XOR 16'h3C5A.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_req_valid;
    logic [15:0] i_req_addr;
    logic        i_req_ready;
    logic        i_resp_valid;
    logic [15:0] i_resp_data;
    logic        i_resp_last;
    logic        d_req_valid;
    logic        d_req_we;
    logic [15:0] d_req_addr;
    logic        d_req_ready;
    logic        d_wdata_ready;
    logic [1:0]  d_wbeat;
    logic [15:0] d_wdata;
    logic        d_resp_valid;
    logic [15:0] d_resp_data;
    logic        d_resp_last;
    logic        d_wr_done;
    logic        mem_en;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;

    logic [15:0] wdata_base;
    int          n_cmp = 0;
    int          n_err = 0;

    mem_arbiter #(
        .ADDR_W      (16),
        .DATA_W      (16),
        .LINE_WORDS  (4),
        .MEM_LATENCY (2)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .i_req_valid   (i_req_valid),
        .i_req_addr    (i_req_addr),
        .i_req_ready   (i_req_ready),
        .i_resp_valid  (i_resp_valid),
        .i_resp_data   (i_resp_data),
        .i_resp_last   (i_resp_last),
        .d_req_valid   (d_req_valid),
        .d_req_we      (d_req_we),
        .d_req_addr    (d_req_addr),
        .d_req_ready   (d_req_ready),
        .d_wdata_ready (d_wdata_ready),
        .d_wbeat       (d_wbeat),
        .d_wdata       (d_wdata),
        .d_resp_valid  (d_resp_valid),
        .d_resp_data   (d_resp_data),
        .d_resp_last   (d_resp_last),
        .d_wr_done     (d_wr_done),
        .mem_en        (mem_en),
        .mem_we        (mem_we),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_rdata     (mem_rdata)
    );

    always #5 clk = ~clk;

    // Memory model: read data appears exactly two cycles after the strobe.
    logic [1:0]  rd_v_q;
    logic [15:0] rd_a0_q, rd_a1_q;
    always @(posedge clk) begin
        rd_v_q  <= {rd_v_q[0], mem_en & ~mem_we};
        rd_a0_q <= mem_addr;
        rd_a1_q <= rd_a0_q;
    end
    assign mem_rdata = rd_v_q[1] ? (rd_a1_q ^ 16'h3C5A) : 16'hDEAD;

    always_comb d_wdata = wdata_base + {14'b0, d_wbeat};

    // Expected {mem_en, mem_we, mem_addr} for a line read, k cycles after grant.
    function automatic logic [17:0] exp_issue(int k, logic [15:0] base);
        if (k >= 1 && k <= 4) return {2'b10, base + 16'(k - 1)};
        return '0;
    endfunction

    // Expected {resp_valid, resp_data, resp_last} for a line read, k cycles after grant.
    function automatic logic [17:0] exp_resp(int k, logic [15:0] base);
        if (k >= 3 && k <= 6) return {1'b1, (base + 16'(k - 3)) ^ 16'h3C5A, k == 6};
        return '0;
    endfunction

    function automatic logic [75:0] all_outputs();
        return {i_req_ready, i_resp_valid, i_resp_data, i_resp_last, d_req_ready,
                d_wdata_ready, d_wbeat, d_resp_valid, d_resp_data, d_resp_last,
                d_wr_done, mem_en, mem_we, mem_addr, mem_wdata};
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        i_req_valid = 1'b0; i_req_addr = '0;
        d_req_valid = 1'b0; d_req_we = 1'b0; d_req_addr = '0;
        wdata_base = '0;
        repeat (3) @(negedge clk);
        #1;
        n_cmp++;
        if (all_outputs() !== '0) begin
            n_err++; $display("FAIL reset_hold: outputs %h want 0", all_outputs());
        end
        @(negedge clk); rst = 1'b0;
        @(negedge clk); #1;
        n_cmp++;
        if (all_outputs() !== '0) begin
            n_err++; $display("FAIL reset_release: outputs %h want 0", all_outputs());
        end
    endtask

    task automatic test_i_fill();
        @(negedge clk); i_req_valid = 1'b1; i_req_addr = 16'h0013; #1;
        n_cmp++;
        if ({i_req_ready, d_req_ready} !== 2'b10) begin
            n_err++; $display("FAIL i_fill_grant: got %b want 10", {i_req_ready, d_req_ready});
        end
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk); i_req_valid = 1'b0; #1;
            n_cmp++;
            if ({mem_en, mem_we, mem_addr} !== exp_issue(k, 16'h0010)) begin
                n_err++; $display("FAIL i_fill_issue k=%0d: got %h want %h", k, {mem_en, mem_we, mem_addr}, exp_issue(k, 16'h0010));
            end
            n_cmp++;
            if ({i_resp_valid, i_resp_data, i_resp_last} !== exp_resp(k, 16'h0010)) begin
                n_err++; $display("FAIL i_fill_resp k=%0d: got %h want %h", k, {i_resp_valid, i_resp_data, i_resp_last}, exp_resp(k, 16'h0010));
            end
            n_cmp++;
            if ({d_resp_valid, d_resp_last} !== 2'b00) begin
                n_err++; $display("FAIL i_fill_d_quiet k=%0d: got %b want 00", k, {d_resp_valid, d_resp_last});
            end
        end
    endtask

    task automatic test_write_back();
        @(negedge clk);
        d_req_valid = 1'b1; d_req_we = 1'b1; d_req_addr = 16'h0020; wdata_base = 16'hA000; #1;
        n_cmp++;
        if ({d_req_ready, i_req_ready} !== 2'b10) begin
            n_err++; $display("FAIL wb_grant: got %b want 10", {d_req_ready, i_req_ready});
        end
        for (int k = 1; k <= 6; k++) begin
            logic [54:0] got, want;
            @(negedge clk); d_req_valid = 1'b0; #1;
            got = {mem_en, mem_we, mem_addr, mem_wdata, d_wdata_ready, d_wbeat, d_wr_done, d_resp_valid};
            if (k <= 4) want = {2'b11, 16'h0020 + 16'(k - 1), 16'hA000 + 16'(k - 1), 1'b1, 2'(k - 1), 1'b0, 1'b0};
            else        want = {53'b0, (k == 5), 1'b0};
            n_cmp++;
            if (got !== want) begin
                n_err++; $display("FAIL wb_beat k=%0d: got %h want %h", k, got, want);
            end
        end
        d_req_we = 1'b0;
    endtask

    task automatic test_simultaneous();
        @(negedge clk);
        i_req_valid = 1'b1; i_req_addr = 16'h0052;
        d_req_valid = 1'b1; d_req_we = 1'b0; d_req_addr = 16'h0031; #1;
        n_cmp++;
        if ({d_req_ready, i_req_ready} !== 2'b10) begin
            n_err++; $display("FAIL simul_grant: got %b want 10", {d_req_ready, i_req_ready});
        end
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk); d_req_valid = 1'b0; #1;
            n_cmp++;
            if ({mem_en, mem_we, mem_addr} !== exp_issue(k, 16'h0030)) begin
                n_err++; $display("FAIL simul_d_issue k=%0d: got %h want %h", k, {mem_en, mem_we, mem_addr}, exp_issue(k, 16'h0030));
            end
            n_cmp++;
            if ({d_resp_valid, d_resp_data, d_resp_last} !== exp_resp(k, 16'h0030)) begin
                n_err++; $display("FAIL simul_d_resp k=%0d: got %h want %h", k, {d_resp_valid, d_resp_data, d_resp_last}, exp_resp(k, 16'h0030));
            end
            n_cmp++;
            if ({i_req_ready, i_resp_valid} !== {(k == 7), 1'b0}) begin
                n_err++; $display("FAIL simul_i_wait k=%0d: got %b want %b", k, {i_req_ready, i_resp_valid}, {(k == 7), 1'b0});
            end
        end
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk); i_req_valid = 1'b0; #1;
            n_cmp++;
            if ({mem_en, mem_we, mem_addr} !== exp_issue(k, 16'h0050)) begin
                n_err++; $display("FAIL simul_i_issue k=%0d: got %h want %h", k, {mem_en, mem_we, mem_addr}, exp_issue(k, 16'h0050));
            end
            n_cmp++;
            if ({i_resp_valid, i_resp_data, i_resp_last, d_resp_valid} !== {exp_resp(k, 16'h0050), 1'b0}) begin
                n_err++; $display("FAIL simul_i_resp k=%0d: got %h want %h", k, {i_resp_valid, i_resp_data, i_resp_last, d_resp_valid}, {exp_resp(k, 16'h0050), 1'b0});
            end
        end
    endtask

    task automatic test_addr_wrap();
        @(negedge clk); d_req_valid = 1'b1; d_req_we = 1'b0; d_req_addr = 16'hFFFE; #1;
        n_cmp++;
        if (d_req_ready !== 1'b1) begin
            n_err++; $display("FAIL wrap_grant: got %b want 1", d_req_ready);
        end
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk); d_req_valid = 1'b0; #1;
            n_cmp++;
            if ({mem_en, mem_we, mem_addr} !== exp_issue(k, 16'hFFFC)) begin
                n_err++; $display("FAIL wrap_issue k=%0d: got %h want %h", k, {mem_en, mem_we, mem_addr}, exp_issue(k, 16'hFFFC));
            end
            n_cmp++;
            if ({d_resp_valid, d_resp_data, d_resp_last, i_resp_valid} !== {exp_resp(k, 16'hFFFC), 1'b0}) begin
                n_err++; $display("FAIL wrap_resp k=%0d: got %h want %h", k, {d_resp_valid, d_resp_data, d_resp_last, i_resp_valid}, {exp_resp(k, 16'hFFFC), 1'b0});
            end
        end
    endtask

    task automatic test_reset_mid_read();
        @(negedge clk); i_req_valid = 1'b1; i_req_addr = 16'h00A0; #1;
        n_cmp++;
        if (i_req_ready !== 1'b1) begin
            n_err++; $display("FAIL rmr_grant: got %b want 1", i_req_ready);
        end
        @(negedge clk); i_req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk); rst = 1'b1; #1;
        n_cmp++;
        if ({mem_en, mem_we, mem_addr} !== 18'h200A2) begin
            n_err++; $display("FAIL rmr_pre_reset_issue: got %h want 200a2", {mem_en, mem_we, mem_addr});
        end
        @(negedge clk); rst = 1'b0; #1;
        n_cmp++;
        if (all_outputs() !== '0) begin
            n_err++; $display("FAIL rmr_outputs_cleared: outputs %h want 0", all_outputs());
        end
        @(negedge clk); i_req_valid = 1'b1; i_req_addr = 16'h00C3; #1;
        n_cmp++;
        if ({i_req_ready, i_resp_valid, d_resp_valid} !== 3'b100) begin
            n_err++; $display("FAIL rmr_regrant: got %b want 100", {i_req_ready, i_resp_valid, d_resp_valid});
        end
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk); i_req_valid = 1'b0; #1;
            n_cmp++;
            if ({mem_en, mem_we, mem_addr, i_resp_valid, i_resp_data, i_resp_last} !== {exp_issue(k, 16'h00C0), exp_resp(k, 16'h00C0)}) begin
                n_err++; $display("FAIL rmr_refill k=%0d: got %h want %h", k, {mem_en, mem_we, mem_addr, i_resp_valid, i_resp_data, i_resp_last}, {exp_issue(k, 16'h00C0), exp_resp(k, 16'h00C0)});
            end
        end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        d_req_valid = 1'b1; d_req_we = 1'b1; d_req_addr = 16'h0084; wdata_base = 16'h5500; #1;
        n_cmp++;
        if (d_req_ready !== 1'b1) begin
            n_err++; $display("FAIL b2b_wr_grant: got %b want 1", d_req_ready);
        end
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk); d_req_valid = 1'b0; i_req_valid = 1'b1; i_req_addr = 16'h0061; #1;
            n_cmp++;
            if ({i_req_ready, d_wr_done, d_wdata_ready} !== {(k == 5), (k == 5), (k <= 4)}) begin
                n_err++; $display("FAIL b2b_wait k=%0d: got %b want %b", k, {i_req_ready, d_wr_done, d_wdata_ready}, {(k == 5), (k == 5), (k <= 4)});
            end
        end
        d_req_we = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk); i_req_valid = 1'b0; #1;
            n_cmp++;
            if ({mem_en, mem_we, mem_addr, i_resp_valid, i_resp_data, i_resp_last} !== {exp_issue(k, 16'h0060), exp_resp(k, 16'h0060)}) begin
                n_err++; $display("FAIL b2b_fill k=%0d: got %h want %h", k, {mem_en, mem_we, mem_addr, i_resp_valid, i_resp_data, i_resp_last}, {exp_issue(k, 16'h0060), exp_resp(k, 16'h0060)});
            end
        end
    endtask

    initial begin
        test_reset();
        test_i_fill();
        test_write_back();
        test_simultaneous();
        test_addr_wrap();
        test_reset_mid_read();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Single-port backing-memory arbiter between the fetch-stage instruction cache and the action-stage data cache. It accepts line-fill reads from both caches and line write-backs from the data cache, and serializes them into word-wide beats to one pipelined memory. It returns read data beat by beat to the requesting cache. It sits directly downstream of the cache request interfaces and replaces the direct cache-to-memory hookup at the top level.

## Interface
- ADDR_W, 16, word address width
- DATA_W, 16, memory word width
- LINE_WORDS, 4, words per cache line (power of two, ≥2)
- MEM_LATENCY, 2, cycles from read issue to mem_rdata valid (≥1)

Ports:
- clk  in  1  clock; one clock domain, all logic on posedge
- rst  in  1  reset, synchronous, active-high
- i_req_valid  in  1  I-cache line-fill request pending (held until granted)
- i_req_addr  in  ADDR_W  I-cache line address; low log2(LINE_WORDS) bits ignored
- i_req_ready  out  1  grant pulse for the I request
- i_resp_valid / i_resp_data / i_resp_last  out  1 / DATA_W / 1  I read beat, data, final beat
- d_req_valid  in  1  D-cache request pending (held until granted)
- d_req_we  in  1  1 = line write-back, 0 = line fill
- d_req_addr  in  ADDR_W  D line address; low bits ignored
- d_req_ready  out  1  grant pulse for the D request
- d_wdata_ready  out  1  write beat consumed this cycle
- d_wbeat  out  log2(LINE_WORDS)  index of the write beat being consumed
- d_wdata  in  DATA_W  write data; must be valid whenever d_wdata_ready=1
- d_resp_valid / d_resp_data / d_resp_last  out  1 / DATA_W / 1  D read beat, data, final beat
- d_wr_done  out  1  one-cycle pulse when the write-back completes
- mem_en, mem_we  out  1, 1  memory access strobe and write enable
- mem_addr, mem_wdata  out  ADDR_W, DATA_W  memory address and write data
- mem_rdata  in  DATA_W  valid exactly MEM_LATENCY cycles after a read strobe

## Operation
- States: IDLE, ISSUE, DRAIN.
- IDLE arbitration uses fixed priority, D over I. The D cache belongs to the older instruction and stalls the whole pipe.
- In IDLE with a request pending, assert the winner's *_req_ready combinationally for that cycle. Latch the owner, we, and base address (low bits zeroed). Go to ISSUE.
- ISSUE: one beat per cycle, beat counter 0..LINE_WORDS-1. mem_en=1 and mem_addr = base + beat, with low bits only; never carry into the tag bits.
  - Read: mem_we=0.
  - Write: mem_we=1, d_wdata_ready=1, d_wbeat=beat, mem_wdata=d_wdata (pass-through).
- After the last beat:
  - Write: go to IDLE, and d_wr_done pulses in the first IDLE cycle.
  - Read: go to DRAIN.
- Read tracking uses a MEM_LATENCY-deep valid/last/owner shift pipe. At its output, the owner's resp_valid=1 and resp_data=mem_rdata (combinational). resp_last marks beat LINE_WORDS-1.
- DRAIN: wait for resp_last, then go to IDLE the next cycle.
- Requests arriving outside IDLE are not granted; the requester holds valid.
- Non-owner resp_valid, resp_last, and wdata_ready stay 0 at all times.
- rst (any state): state=IDLE, counters=0, tracking pipe cleared. In-flight mem_rdata after reset is never reported.
- Reset values: all outputs 0. mem_addr and mem_wdata read as 0.

## Timing
Figures below use LINE_WORDS=4, MEM_LATENCY=2, with grant in cycle T.
- Read: issues at T+1..T+4. Responses arrive at T+3..T+6, with last at T+6. IDLE at T+7, so the earliest next grant is T+7.
- General read occupancy: 1 + LINE_WORDS + MEM_LATENCY cycles, grant cycle included.
- Write: beats at T+1..T+4. d_wr_done and IDLE at T+5, and a new grant is possible at T+5.
- Simultaneous i/d valid in IDLE: D granted; I waits until the next IDLE.
- No combinational path from mem_rdata to any request-side input.

## Structure
- nand_cpu.svh holds the `MEM_ADDR_SIZE and `MEM_WORD_SIZE defines and the mem_arb_state_t enum (IDLE, ISSUE, DRAIN).
- Sub-module mem_read_tracker holds the MEM_LATENCY-deep valid/last/owner shift pipe and its clear on rst.
- Top level: instantiate between I_CACHE/D_CACHE and MEMORY.

## Test plan
- **I fill, idle arbiter:** i_req_valid, addr 0x0013 at T → mem_addr 0x0010..0x0013 at T+1..T+4 with mem_we=0; i_resp_valid at T+3..T+6; i_resp_last only at T+6; d_resp_valid never asserted.
- **D write-back:** addr 0x0020, d_wdata = 0xA000+d_wbeat → mem_we=1 with mem_wdata A000..A003 at 0x20..0x23, T+1..T+4; d_wr_done single pulse at T+5.
- **Simultaneous requests:** i and d valid at T (D read) → d_req_ready at T, i_req_ready at T+7; I beats at 0x..0..3 follow correctly.
- **Address wrap:** D fill addr 0xFFFE → beats 0xFFFC..0xFFFF, no carry into higher bits.
- **Reset mid-read:** rst at T+3 → all outputs 0 from T+4; no resp_valid from in-flight reads; new I request at T+5 granted same cycle.
- **Back-to-back:** D write then I fill held pending → I grant exactly at the write's T+5.
